// File: rtl/fwvip_wb_target_mem.sv
// Wishbone classic-cycle target with a word-addressed memory, a fixed number
// of wait states and an error termination for addresses beyond DEPTH.
//
// state  | meaning
// IDLE   | waiting for cyc && stb; request fields are latched on accept
// WAIT   | counting down wait states; a cyc/stb drop aborts the transfer
// RESP   | ack (in range) or err (out of range) high; write commits at the end
// GAP    | one quiet cycle so a held stb is not accepted twice
module fwvip_wb_target_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   adr,
  input  logic [DATA_WIDTH-1:0]   dat_w,
  output logic [DATA_WIDTH-1:0]   dat_r,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic                    stb,
  input  logic                    cyc,
  output logic                    ack,
  output logic                    err
);

  localparam int         BYTES   = DATA_WIDTH / 8;
  localparam int         SHIFT   = $clog2(BYTES);
  localparam int         IDX_W   = $clog2(DEPTH);
  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_GAP
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [IDX_W-1:0]      idx_q;
  logic                  hit_q;
  logic                  we_q;
  logic [BYTES-1:0]      sel_q;
  logic [DATA_WIDTH-1:0] dat_w_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] widx;
  logic                  in_hit;
  logic                  accept;
  logic                  resp_hit;
  logic [IDX_W-1:0]      resp_idx;
  logic                  enter_resp;

  // Word index of the incoming address; any bit above the memory index means out of range.
  assign widx   = adr >> SHIFT;
  assign in_hit = ((widx >> IDX_W) == '0);
  assign accept = (state_q == ST_IDLE) && cyc && stb;

  // With zero wait states RESP is entered straight from IDLE, so the response
  // must be formed from the live request rather than the latched copy.
  assign resp_hit   = (state_q == ST_IDLE) ? in_hit : hit_q;
  assign resp_idx   = (state_q == ST_IDLE) ? widx[IDX_W-1:0] : idx_q;
  assign enter_resp = (state_d == ST_RESP);

  // Next-state and wait counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = WS_INIT;
          if (WAIT_STATES > 0) state_d = ST_WAIT;
          else                 state_d = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (!cyc || !stb) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request on accept; later input changes are ignored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      hit_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_w_q <= '0;
    end else if (accept) begin
      idx_q   <= widx[IDX_W-1:0];
      hit_q   <= in_hit;
      we_q    <= we;
      sel_q   <= sel;
      dat_w_q <= dat_w;
    end
  end

  // Registered termination and read data, loaded on the edge that enters RESP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ack   <= 1'b0;
      err   <= 1'b0;
      dat_r <= '0;
    end else begin
      ack   <= enter_resp && resp_hit;
      err   <= enter_resp && !resp_hit;
      dat_r <= (enter_resp && resp_hit) ? mem[resp_idx] : '0;
    end
  end

  // Byte-lane write at the edge that ends RESP; contents survive reset.
  always_ff @(posedge clock) begin
    if ((state_q == ST_RESP) && we_q && hit_q) begin
      for (int i = 0; i < BYTES; i++) begin
        if (sel_q[i]) mem[idx_q][i*8 +: 8] <= dat_w_q[i*8 +: 8];
      end
    end
  end

endmodule

// File: doc/fwvip_wb_target_mem.md
# fwvip_wb_target_mem

Wishbone classic-cycle responder (target) with internal word-addressed memory, programmable wait states and error response for out-of-range addresses. It is the far end of the `fwvip_wb_initiator` interface: it replaces ad-hoc target models in initiator benches and serves as a reusable memory-mapped endpoint in `fwvip_wb` testbenches.

## Interface
- `ADDR_WIDTH`, 32, byte-address width of `adr`.
- `DATA_WIDTH`, 32, data width; must be 8, 16, 32 or 64.
- `DEPTH`, 256, memory depth in words; power of two, ≥2.
- `WAIT_STATES`, 0, extra cycles inserted before `ack`/`err` (0–15).
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to `clock` externally).
- `adr`  in  ADDR_WIDTH  byte address.
- `dat_w`  in  DATA_WIDTH  write data.
- `dat_r`  out  DATA_WIDTH  read data; valid only while `ack`=1.
- `we`  in  1  1=write, 0=read.
- `sel`  in  DATA_WIDTH/8  byte-lane enables.
- `stb`  in  1  transfer strobe.
- `cyc`  in  1  bus cycle valid.
- `ack`  out  1  normal termination, one-cycle pulse.
- `err`  out  1  error termination, one-cycle pulse.

## Operation
- Word index = `adr >> log2(DATA_WIDTH/8)`; low byte-offset bits ignored. Index ≥ DEPTH (including nonzero upper bits) is out of range.
- FSM states: IDLE, WAIT, RESP, GAP.
  - IDLE: on `cyc && stb` latch `adr`, `we`, `sel`, `dat_w`; wait counter ← WAIT_STATES. Go WAIT if WAIT_STATES>0, else RESP.
  - WAIT: decrement counter each cycle; at 1 go RESP. If `cyc` or `stb` drops, abort to IDLE, no write.
  - RESP: `ack`=1 (in range) or `err`=1 (out of range), never both. Write commits at the rising edge ending RESP: byte i written iff `sel[i]`. Read: `dat_r` = stored word (pre-write content). On err `dat_r` = 0, no write. Next state GAP.
  - GAP: `ack`=`err`=0 for one cycle, unconditionally; next IDLE. Prevents double-acceptance of a held `stb`.
- `ack`/`err`/`dat_r` registered (driven from state, no combinational input path).
- Request fields are latched in IDLE; input changes during WAIT/RESP (other than `cyc`/`stb` drop in WAIT) are ignored.
- `stb` without `cyc` is ignored.
- Memory contents are not cleared by reset; read of never-written location returns X in sim.

## Timing
- Reset values: `ack`=0, `err`=0, `dat_r`=0, state IDLE, counter 0. Reset mid-transfer: outputs clear immediately, pending write discarded.
- Request sampled at edge E (state IDLE) → `ack`/`err` high in cycle E+1+WAIT_STATES, for exactly one cycle.
- Back-to-back throughput: one transfer per WAIT_STATES+3 cycles (IDLE, WAIT×n, RESP, GAP).
- Write visible to a read that begins at the earliest next accept (after GAP).
- `cyc` drop during RESP: response still completes and write commits; initiator must not rely on abort after RESP starts.

## Test plan
- WAIT_STATES=0: write 0xDEADBEEF to adr 0x10, sel=4'hF, then read adr 0x10 → `ack` one cycle after each request, read `dat_r`=0xDEADBEEF, `err` never high.
- Byte lanes: write 0x11223344 sel=F to adr 0x20, then 0xAABBCCDD sel=4'b0101 → read gives 0x11BB33DD.
- WAIT_STATES=3: single read → `ack` exactly 4 cycles after request edge; held `stb` produces second `ack` no earlier than 6 cycles after the first.
- Out of range (DEPTH=256, adr 0x400): write then read → `err` pulses, `ack`=0, `dat_r`=0; location 0x000 (alias) unchanged.
- Abort: WAIT_STATES=4, write to 0x30 with `cyc` dropped after 2 cycles → no `ack`/`err`; subsequent read of 0x30 returns prior value.
- Reset: assert `reset`=0 during WAIT of a write → `ack`, `err`, `dat_r` go 0 without a clock edge; after release, read of target address returns the pre-write value.
